// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO completer: register offsets and the transfer FSM encoding.
package apb_gpio_pkg;

    localparam logic [4:0] ADDR_DATA_OUT = 5'h00;
    localparam logic [4:0] ADDR_DIR      = 5'h04;
    localparam logic [4:0] ADDR_DATA_IN  = 5'h08;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'h10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } apb_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchronizer with an optional rising-edge detector (enabled by GPIO_IRQ_EN).
module gpio_sync_edge #(
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] pins,
    output logic [GPIO_WIDTH-1:0] sync,
    output logic [GPIO_WIDTH-1:0] rise
);

    logic [GPIO_WIDTH-1:0] meta_q;
    logic [GPIO_WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pins;
            sync_q <= meta_q;
        end
    end

    assign sync = sync_q;

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
`else
    assign rise = '0;
`endif

endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 GPIO completer with configurable wait states; the IRQ registers exist only when
// GPIO_IRQ_EN is defined.
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  pclk,
    input  logic                  Reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [4:0]            paddr,
    input  logic [31:0]           pwdata,
    output logic                  pready,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES - 1);

    apb_state_e state_q, state_d;
    logic [3:0] wait_q, wait_d;

    logic                  access;
    logic                  commit;
    logic                  sel_out, sel_dir, sel_in;
    logic                  mapped, err;
    logic [31:0]           rdata;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] data_out_q, dir_q;
    logic [GPIO_WIDTH-1:0] sync, rise;
    logic [31:0]           prdata_q;
    logic                  pslverr_q;
    logic                  unused_bits;

    assign access = psel & penable;
    assign wdata  = pwdata[GPIO_WIDTH-1:0];
    // Registers and read data are updated on the edge that enters DONE, so they line up with pready.
    assign commit = (state_d == StDone) && (state_q != StDone);

    gpio_sync_edge #(
        .GPIO_WIDTH(GPIO_WIDTH)
    ) u_sync (
        .clk  (pclk),
        .reset(Reset),
        .pins (gpio_in),
        .sync (sync),
        .rise (rise)
    );

    always_ff @(posedge pclk) begin
        if (Reset) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    wait_d  = '0;
                    state_d = (WAIT_STATES == 0) ? StDone : StWait;
                end
            end
            StWait: begin
                if (!access) begin
                    state_d = StIdle;
                    wait_d  = '0;
                end else if (wait_q == WaitLast) begin
                    state_d = StDone;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pready  = (state_q == StDone);
        prdata  = prdata_q;
        pslverr = pslverr_q;
    end

    assign sel_out = (paddr == ADDR_DATA_OUT);
    assign sel_dir = (paddr == ADDR_DIR);
    assign sel_in  = (paddr == ADDR_DATA_IN);

`ifdef GPIO_IRQ_EN
    logic                  sel_en, sel_stat;
    logic [GPIO_WIDTH-1:0] irq_en_q, irq_stat_q, irq_stat_d, w1c_mask;
    logic                  irq_q;

    assign sel_en   = (paddr == ADDR_IRQ_EN);
    assign sel_stat = (paddr == ADDR_IRQ_STAT);
    assign mapped   = sel_out | sel_dir | sel_in | sel_en | sel_stat;
    assign w1c_mask = (commit && pwrite && sel_stat) ? wdata : '0;
    // A new edge in the same cycle as a W1C keeps the bit set.
    assign irq_stat_d = (irq_stat_q & ~w1c_mask) | rise;

    always_ff @(posedge pclk) begin
        if (Reset) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (commit && pwrite && sel_en) begin
                irq_en_q <= wdata;
            end
            irq_stat_q <= irq_stat_d;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign irq = irq_q;
`else
    assign mapped = sel_out | sel_dir | sel_in;
    assign irq    = 1'b0;
`endif

    assign err = !mapped || (pwrite && sel_in);

    always_comb begin
        rdata = '0;
        if (sel_out) rdata = 32'(data_out_q);
        if (sel_dir) rdata = 32'(dir_q);
        if (sel_in)  rdata = 32'(sync);
`ifdef GPIO_IRQ_EN
        if (sel_en)   rdata = 32'(irq_en_q);
        if (sel_stat) rdata = 32'(irq_stat_q);
`endif
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            data_out_q <= '0;
            dir_q      <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
        end else begin
            if (commit && pwrite && sel_out) begin
                data_out_q <= wdata;
            end
            if (commit && pwrite && sel_dir) begin
                dir_q <= wdata;
            end
            prdata_q  <= (commit && !pwrite && !err) ? rdata : '0;
            pslverr_q <= commit && err;
        end
    end

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;

    assign unused_bits = ^{pwdata, rise};

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed self-checking bench for apb_gpio_slave (GPIO_WIDTH=8, WAIT_STATES=1); the IRQ section
// follows GPIO_IRQ_EN.
module tb_apb_gpio_slave;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    int          lat_v;
    logic [31:0] rd_v;
    logic        err_v;
    int          rdy_seen;

    always #5 pclk = ~pclk;

    apb_gpio_slave #(
        .GPIO_WIDTH (8),
        .WAIT_STATES(1)
    ) dut (
        .pclk    (pclk),
        .Reset   (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full SETUP + ACCESS transfer; optionally changes gpio_in on the SETUP cycle.
    task automatic xfer(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        input logic pin_chg, input logic [7:0] pin_val);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        if (pin_chg) gpio_in = pin_val;
        @(negedge pclk);
        penable = 1'b1;
        lat_v = -1; rd_v = '0; err_v = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge pclk);
            #1;
            if (pready) begin
                lat_v = i; rd_v = prdata; err_v = pslverr;
                break;
            end
        end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        xfer(1'b1, addr, data, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [4:0] addr);
        xfer(1'b0, addr, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        cycles(3);
        check("rst pready", {31'b0, pready}, 32'h0);
        check("rst prdata", prdata, 32'h0);
        check("rst pslverr", {31'b0, pslverr}, 32'h0);
        check("rst gpio_out", {24'b0, gpio_out}, 32'h0);
        check("rst gpio_oe", {24'b0, gpio_oe}, 32'h0);
        check("rst irq", {31'b0, irq}, 32'h0);
        @(negedge pclk);
        rst = 1'b0;

        // DATA_OUT write/read with one wait state
        wr(5'h00, 32'hA5);
        check("wr0 latency", lat_v, 32'd2);
        check("wr0 pslverr", {31'b0, err_v}, 32'h0);
        check("wr0 gpio_out", {24'b0, gpio_out}, 32'hA5);
        rd(5'h00);
        check("rd0 latency", lat_v, 32'd2);
        check("rd0 prdata", rd_v, 32'h0000_00A5);
        check("rd0 pslverr", {31'b0, err_v}, 32'h0);

        // DIR and width masking
        wr(5'h04, 32'h0F);
        check("dir gpio_oe", {24'b0, gpio_oe}, 32'h0F);
        rd(5'h04);
        check("dir readback", rd_v, 32'h0F);
        wr(5'h00, 32'h1FF);
        check("mask gpio_out", {24'b0, gpio_out}, 32'hFF);
        rd(5'h00);
        check("mask readback", rd_v, 32'hFF);

        // Synchronized input, read-only DATA_IN
        @(negedge pclk);
        gpio_in = 8'h3C;
        cycles(2);
        rd(5'h08);
        check("din read", rd_v, 32'h3C);
        wr(5'h08, 32'h11);
        check("din wr err", {31'b0, err_v}, 32'h1);
        rd(5'h08);
        check("din unchanged", rd_v, 32'h3C);

        // Unmapped and misaligned addresses
        rd(5'h14);
        check("unmapped err", {31'b0, err_v}, 32'h1);
        check("unmapped data", rd_v, 32'h0);
        rd(5'h02);
        check("misalign err", {31'b0, err_v}, 32'h1);
        check("misalign data", rd_v, 32'h0);

        // psel dropped during WAIT aborts the write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h55;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk);
            #1;
            if (pready) rdy_seen++;
        end
        check("abort pready", rdy_seen, 32'd0);
        check("abort gpio_out", {24'b0, gpio_out}, 32'hFF);

`ifdef GPIO_IRQ_EN
        wr(5'h10, 32'hFF);
        rd(5'h10);
        check("stat cleared", rd_v, 32'h0);
        wr(5'h0C, 32'h01);
        @(negedge pclk);
        gpio_in = 8'h3D;
        cycles(3);
        check("irq before reg", {31'b0, irq}, 32'h0);
        cycles(1);
        check("irq set", {31'b0, irq}, 32'h1);
        rd(5'h10);
        check("stat set", rd_v, 32'h01);
        @(negedge pclk);
        gpio_in = 8'h3C;
        cycles(4);
        // W1C commit coincides with a fresh pin0 rising edge
        xfer(1'b1, 5'h10, 32'h01, 1'b1, 8'h3D);
        rd(5'h10);
        check("set wins", rd_v, 32'h01);
        check("irq held", {31'b0, irq}, 32'h1);
        wr(5'h10, 32'h01);
        rd(5'h10);
        check("w1c clear", rd_v, 32'h0);
        check("irq clear", {31'b0, irq}, 32'h0);
`else
        rd(5'h0C);
        check("irq_en unmapped", {31'b0, err_v}, 32'h1);
        wr(5'h10, 32'h01);
        check("irq_stat unmapped", {31'b0, err_v}, 32'h1);
        check("irq tied", {31'b0, irq}, 32'h0);
`endif

        // Reset during WAIT of a DIR write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'hFF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        rst = 1'b1;
        @(posedge pclk);
        #1;
        check("mid rst pready", {31'b0, pready}, 32'h0);
        check("mid rst gpio_oe", {24'b0, gpio_oe}, 32'h0);
        check("mid rst gpio_out", {24'b0, gpio_out}, 32'h0);
        check("mid rst pslverr", {31'b0, pslverr}, 32'h0);
        check("mid rst irq", {31'b0, irq}, 32'h0);
        @(negedge pclk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        wr(5'h04, 32'h33);
        check("post rst latency", lat_v, 32'd2);
        check("post rst gpio_oe", {24'b0, gpio_oe}, 32'h33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_gpio_slave.md
Name: apb_gpio_slave

Overview:
APB3-style completer that sits directly downstream of the APB bridge, driven by its PSEL1 select and shared pwrite/penable/paddr/pwdata. Exposes a small GPIO register file: output data, direction, synchronized input, and rising-edge interrupt. Returns pready/prdata/pslverr to the bridge, with configurable wait states.

Parameters:
GPIO_WIDTH, 8, number of GPIO pins (1..32); register bits above GPIO_WIDTH read 0 and ignore writes.
WAIT_STATES, 1, access-phase cycles with pready=0 before completion (0..15).

Ports:
pclk  input  1  single clock, rising edge.
Reset  input  1  synchronous, active-high reset.
psel  input  1  select from the bridge (PSEL1).
penable  input  1  APB enable.
pwrite  input  1  1=write, 0=read.
paddr  input  5  byte address.
pwdata  input  32  write data.
pready  output  1  transfer-complete strobe.
prdata  output  32  read data; valid only when pready=1.
pslverr  output  1  error; valid only when pready=1.
gpio_in  input  GPIO_WIDTH  asynchronous pin inputs.
gpio_out  output  GPIO_WIDTH  output data register.
gpio_oe  output  GPIO_WIDTH  output enable (DIR register).
irq  output  1  level interrupt.

Behaviour:
- Reset (sync, pclk edge with Reset=1): pready=0, prdata=0, pslverr=0, gpio_out=0, gpio_oe=0, irq=0, IRQ_EN=0, IRQ_STAT=0, synchronizer flops=0, FSM=IDLE, wait counter=0. Reset mid-transfer aborts it with no register update.
- Register map (paddr): 0x00 DATA_OUT RW; 0x04 DIR RW (1=output); 0x08 DATA_IN RO; 0x0C IRQ_EN RW; 0x10 IRQ_STAT RW1C. Any other address, or paddr[1:0]!=0 -> pslverr=1, no state change, prdata=0. Write to DATA_IN -> pslverr=1, ignored.
- FSM: IDLE -> WAIT when psel=1 and penable=1 (access phase) and WAIT_STATES>0; IDLE -> DONE directly when WAIT_STATES=0. WAIT counts WAIT_STATES cycles, pready=0, then -> DONE. DONE: pready=1 for exactly one cycle, prdata/pslverr valid, write committed on this cycle's edge; -> IDLE next cycle. Total latency from first access-phase cycle to pready: WAIT_STATES+1 cycles (pready registered).
- psel or penable dropping in WAIT: abort to IDLE, no write, pready stays 0.
- Back-to-back: after DONE, FSM needs one IDLE cycle; bridge's SETUP phase provides it.
- pready, prdata, pslverr are 0 whenever not in DONE.
- gpio_in passes a 2-flop synchronizer; DATA_IN reads the 2nd flop (pin-to-readable latency 2 cycles). A 3rd flop holds previous value; rising edge = sync & ~prev.
- IRQ_STAT[i] set on rising edge of pin i regardless of IRQ_EN; irq = |(IRQ_STAT & IRQ_EN), registered (1 cycle after set).
- Simultaneous W1C and new edge on same bit: set wins.
- Pins configured as output still feed DATA_IN and edge detection.

Optional Feature:
GPIO_IRQ_EN. Defined: IRQ_EN/IRQ_STAT, edge detect, irq as above. Undefined: no 3rd flop or IRQ logic; 0x0C/0x10 are unmapped (pslverr=1); irq tied 0; port list unchanged.

Decomposition:
- Shared package apb_gpio_pkg: register address constants (ADDR_DATA_OUT, ADDR_DIR, ADDR_DATA_IN, ADDR_IRQ_EN, ADDR_IRQ_STAT), FSM state encoding (IDLE, WAIT, DONE).
- One sub-module: gpio_sync_edge (per-bus 2-flop synchronizer plus optional rising-edge detector), parameterized by GPIO_WIDTH.

Test Plan:
- Reset then write 0x00=0xA5, WAIT_STATES=1 -> pready high 2 cycles after access start, pslverr=0, gpio_out=0xA5; read 0x00 -> prdata=0x000000A5.
- Write 0x04=0x0F, read 0x04 -> gpio_oe=0x0F, prdata=0x0F; write 0x00=0x1FF (GPIO_WIDTH=8) -> readback 0xFF.
- gpio_in 0x00->0x3C, wait 2 cycles, read 0x08 -> prdata=0x3C; write 0x08 -> pslverr=1, DATA_IN unchanged.
- Read 0x14 and 0x02 -> pslverr=1, prdata=0; drop psel during WAIT on a write 0x00=0x55 -> no pready, gpio_out unchanged.
- GPIO_IRQ_EN: IRQ_EN=0x01, pin0 rising -> IRQ_STAT=0x01, irq=1 next cycle; write IRQ_STAT=0x01 on same cycle as new pin0 edge -> bit stays 1; clean W1C -> irq=0.
- Assert Reset during WAIT of a write 0x04=0xFF -> all outputs 0, gpio_oe=0, next transfer completes normally.
